// File: rtl/cordic_vector_iter_if.sv
// Vector-in / magnitude+phase-out handshake bundle for cordic_vector_iter.
interface cordic_vector_iter_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] X_in;
  logic [W-1:0] Y_in;
  logic         in_valid;
  logic         in_ready;
  logic [W+1:0] MAG;
  logic [31:0]  ANGLE;
  logic         Z_31;
  logic         Z_30;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output X_in, Y_in, in_valid, out_ready,
    input  in_ready, MAG, ANGLE, Z_31, Z_30, out_valid
  );

  modport slave (
    input  X_in, Y_in, in_valid, out_ready,
    output in_ready, MAG, ANGLE, Z_31, Z_30, out_valid
  );
endinterface

// File: rtl/cordic_vector_iter.sv
// Iterative vectoring-mode CORDIC: signed (X,Y) -> magnitude and 32-bit phase.
// Define CORDIC_GAIN_COMP_EN to add a GAIN cycle that scales MAG by 1/K.
module cordic_vector_iter #(
  parameter int unsigned W    = 32,
  parameter int unsigned ITER = 30
) (
  input  logic                 C,
  input  logic                 CLR_N,
  input  logic                 CE,
  cordic_vector_iter_if.slave  bus
);
  localparam int unsigned DW = W + 2;
  localparam int unsigned CW = 5;
  localparam logic [31:0] INV_GAIN = 32'h9B74_EDA8;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_GAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d;
  logic signed [DW-1:0] x_sh, y_sh, x_rot, y_rot;
  logic [31:0]          z_q, z_d, z_rot;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 zero_q, zero_d;
  logic [DW-1:0]        mag_q, mag_d;
  logic [31:0]          angle_q, angle_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
`ifdef CORDIC_GAIN_COMP_EN
  logic [DW+31:0]       prod;
`endif

  // round(atan(2^-i) * 2^32 / (2*pi))
  function automatic logic [31:0] atan_lut(input logic [CW-1:0] i);
    case (i)
      5'd0:  atan_lut = 32'h2000_0000;
      5'd1:  atan_lut = 32'h12E4_051E;
      5'd2:  atan_lut = 32'h09FB_385B;
      5'd3:  atan_lut = 32'h0511_11D4;
      5'd4:  atan_lut = 32'h028B_0D43;
      5'd5:  atan_lut = 32'h0145_D7E1;
      5'd6:  atan_lut = 32'h00A2_F61E;
      5'd7:  atan_lut = 32'h0051_7C55;
      5'd8:  atan_lut = 32'h0028_BE53;
      5'd9:  atan_lut = 32'h0014_5F2F;
      5'd10: atan_lut = 32'h000A_2F98;
      5'd11: atan_lut = 32'h0005_17CC;
      5'd12: atan_lut = 32'h0002_8BE6;
      5'd13: atan_lut = 32'h0001_45F3;
      5'd14: atan_lut = 32'h0000_A2FA;
      5'd15: atan_lut = 32'h0000_517D;
      5'd16: atan_lut = 32'h0000_28BE;
      5'd17: atan_lut = 32'h0000_145F;
      5'd18: atan_lut = 32'h0000_0A30;
      5'd19: atan_lut = 32'h0000_0518;
      5'd20: atan_lut = 32'h0000_028C;
      5'd21: atan_lut = 32'h0000_0146;
      5'd22: atan_lut = 32'h0000_00A3;
      5'd23: atan_lut = 32'h0000_0051;
      5'd24: atan_lut = 32'h0000_0029;
      5'd25: atan_lut = 32'h0000_0014;
      5'd26: atan_lut = 32'h0000_000A;
      5'd27: atan_lut = 32'h0000_0005;
      5'd28: atan_lut = 32'h0000_0003;
      5'd29: atan_lut = 32'h0000_0001;
      5'd30: atan_lut = 32'h0000_0001;
      default: atan_lut = 32'h0000_0000;
    endcase
  endfunction

  // One micro-rotation driving Y toward zero
  always_comb begin
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    if (y_q[DW-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_lut(cnt_q);
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_lut(cnt_q);
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  // X_final is non-negative after pre-rotation, so an unsigned product is exact
  always_comb prod = {32'b0, x_q} * {{DW{1'b0}}, INV_GAIN};
`endif

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    angle_d = angle_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d     = DW'($signed(bus.X_in));
          y_d     = DW'($signed(bus.Y_in));
          zero_d  = (bus.X_in == '0) && (bus.Y_in == '0);
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        // Fold left half-plane into |angle| <= 90 deg
        if (!x_q[DW-1]) begin
          z_d = 32'h0000_0000;
        end else if (!y_q[DW-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = 32'h4000_0000;
        end else begin
          x_d = -y_q;
          y_d = x_q;
          z_d = 32'hC000_0000;
        end
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_GAIN;
`else
          mag_d   = zero_q ? '0 : DW'(x_rot);
          angle_d = zero_q ? '0 : z_rot;
          state_d = S_DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_GAIN: begin
        mag_d   = zero_q ? '0 : prod[DW+31:32];
        angle_d = zero_q ? '0 : z_q;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      mag_q       <= '0;
      angle_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (CE) begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      mag_q       <= mag_d;
      angle_q     <= angle_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.MAG       = mag_q;
  assign bus.ANGLE     = angle_q;
  assign bus.Z_31      = angle_q[31];
  assign bus.Z_30      = angle_q[30];
endmodule

// File: tb/tb_cordic_vector_iter.sv
// Randomized + directed bench for cordic_vector_iter against a real-arithmetic atan2/hypot model.
module tb_cordic_vector_iter;
  localparam int unsigned W    = 32;
  localparam int unsigned ITER = 30;
  localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 3;
  localparam real GSCALE = 2608131496.0 / 4294967296.0;
`else
  localparam int LAT = ITER + 2;
  localparam real GSCALE = 1.0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ce    = 1'b1;
  int   checks = 0;
  int   errors = 0;
  real  k_gain = 1.0;

  cordic_vector_iter_if #(.W(W)) bus ();

  cordic_vector_iter #(.W(W), .ITER(ITER)) dut (
    .C     (clk),
    .CLR_N (rst_n),
    .CE    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol, input bit wrap32);
    longint d;
    checks++;
    d = got - exp;
    if (wrap32) d = longint'($signed(32'(d)));
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint exp_ang(input longint x, input longint y);
    real a;
    if (x == 0 && y == 0) return 0;
    a = $atan2(real'(y), real'(x)) / (2.0 * PI) * 4294967296.0;
    if (a < 0.0) a = a + 4294967296.0;
    return longint'(a) & 64'hFFFF_FFFF;
  endfunction

  function automatic longint exp_mag(input longint x, input longint y);
    real r;
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * k_gain * GSCALE;
    return longint'(r);
  endfunction

  task automatic run_vec(input string tag, input longint x, input longint y,
                         input int stall_len, input int hold);
    longint em, ea, tol, q;
    int cyc;
    em  = exp_mag(x, y);
    ea  = exp_ang(x, y);
    tol = (x == 0 && y == 0) ? 0 : 256;
    bus.X_in     = W'(x);
    bus.Y_in     = W'(y);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    cyc = 0;
    while (!bus.in_ready) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 20) begin
        check({tag, "_accept"}, 0, 1, 0, 1'b0);
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      if (stall_len > 0 && cyc == 6) ce = 1'b0;
      if (stall_len > 0 && cyc == 6 + stall_len) ce = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    ce = 1'b1;
    check({tag, "_latency"}, cyc, LAT + stall_len, 0, 1'b0);
    if (!bus.out_valid) return;
    check({tag, "_mag"}, bus.MAG, em, tol, 1'b0);
    check({tag, "_angle"}, bus.ANGLE, ea, tol, 1'b1);
    check({tag, "_busy"}, bus.in_ready, 0, 0, 1'b0);
    // Quadrant flags are only unambiguous away from a 90-degree boundary
    q = ea & 64'h3FFF_FFFF;
    if (q > 1024 && q < 64'h3FFF_FFFF - 1024) begin
      check({tag, "_z31"}, bus.Z_31, (ea >> 31) & 1, 0, 1'b0);
      check({tag, "_z30"}, bus.Z_30, (ea >> 30) & 1, 0, 1'b0);
    end
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check({tag, "_hold_valid"}, bus.out_valid, 1, 0, 1'b0);
      check({tag, "_hold_busy"}, bus.in_ready, 0, 0, 1'b0);
      check({tag, "_hold_angle"}, bus.ANGLE, ea, tol, 1'b1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, bus.out_valid, 0, 0, 1'b0);
    check({tag, "_idle_ready"}, bus.in_ready, 1, 0, 1'b0);
    check({tag, "_retain_mag"}, bus.MAG, em, tol, 1'b0);
  endtask

  initial begin
    longint rx, ry;
    for (int i = 0; i < int'(ITER); i++) k_gain = k_gain * $sqrt(1.0 + $pow(2.0, -2.0 * i));
    bus.X_in      = '0;
    bus.Y_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0, 0, 1'b0);
    check("rst_out_valid", bus.out_valid, 0, 0, 1'b0);
    check("rst_mag", bus.MAG, 0, 0, 1'b0);
    check("rst_angle", bus.ANGLE, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_release_ready", bus.in_ready, 1, 0, 1'b0);

    run_vec("t1_x", 64'sh4000_0000, 0, 0, 0);
    run_vec("t2_y", 0, 64'sh4000_0000, 0, 0);
    run_vec("t3_neg_x", -64'sh4000_0000, -1, 0, 0);
    run_vec("t3_q4", 64'sh4000_0000, -64'sh4000_0000, 0, 0);
    run_vec("t4_zero", 0, 0, 0, 0);
    run_vec("t4_min", -64'sh8000_0000, -64'sh8000_0000, 0, 0);
    run_vec("t5_hold", 64'sh3000_0000, 64'sh1234_5678, 0, 5);
    run_vec("t5_stall", -64'sh2345_6789, 64'sh5000_0000, 3, 0);

    // Async reset in the middle of the iterations discards the vector
    bus.X_in     = 32'h2000_0000;
    bus.Y_in     = 32'h1000_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 0, 0, 1'b0);
    check("midrst_ready", bus.in_ready, 0, 0, 1'b0);
    check("midrst_angle", bus.ANGLE, 0, 0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_rel_ready", bus.in_ready, 1, 0, 1'b0);
    check("midrst_rel_valid", bus.out_valid, 0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      do begin
        rx = longint'($signed($urandom()));
        ry = longint'($signed($urandom()));
      end while ((rx < 64'sh1000_0000 && rx > -64'sh1000_0000) &&
                 (ry < 64'sh1000_0000 && ry > -64'sh1000_0000));
      run_vec($sformatf("rnd%0d", n), rx, ry, 0, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
